// File: rtl/vend_dispense_ctrl.sv
// Vend/change dispense controller: queues {prod, coins} requests and drives motor/hopper pulses, each confirmed by a sensor.
// Latency: request to motor/hopper high is 2 cycles; a capture while the queue is full is dropped and sets sticky overflow.
module vend_dispense_ctrl #(
  parameter int PULSE_W = 4,
  parameter int TIMEOUT = 64,
  parameter int DEPTH   = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       out,
  input  logic [1:0] change,
  input  logic       drop_sense,
  input  logic       coin_sense,
  output logic       motor,
  output logic       hopper,
  output logic       busy,
  output logic       full,
  output logic       overflow,
  output logic       fault
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int TMAX  = (TIMEOUT > PULSE_W) ? TIMEOUT : PULSE_W;
  localparam int TMR_W = $clog2(TMAX + 1);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_MOTOR     = 3'd1;
  localparam logic [2:0] S_WAIT_DROP = 3'd2;
  localparam logic [2:0] S_COIN      = 3'd3;
  localparam logic [2:0] S_WAIT_COIN = 3'd4;
  localparam logic [2:0] S_FAULT     = 3'd5;

  typedef struct packed {
    logic       prod;
    logic [1:0] coins;
  } entry_t;

  logic [2:0]       state_q, state_d;
  logic [TMR_W-1:0] tmr_q, tmr_d;
  logic [1:0]       coins_q, coins_d;
  logic [2:0]       req_prev_q, req_prev_d;
  entry_t           mem_q [DEPTH];
  entry_t           mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             overflow_q, overflow_d;

  logic [2:0] req;
  logic       capture;
  logic       pop;
  logic       push;
  entry_t     head;

  always_comb begin
    req     = {out, change};
    // A held level counts once; the FAULT state freezes the queue entirely.
    capture = (req != 3'b000) && (req != req_prev_q) && (state_q != S_FAULT);
    full    = (count_q == CNT_W'(DEPTH));
    pop     = (state_q == S_IDLE) && (count_q != '0);
    push    = capture && (!full || pop);
    head    = mem_q[rd_ptr_q];

    req_prev_d = req;
    mem_d      = mem_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q | (capture && full && !pop);

    if (push) begin
      mem_d[wr_ptr_q] = entry_t'(req);
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase

    state_d = state_q;
    tmr_d   = tmr_q;
    coins_d = coins_q;
    case (state_q)
      S_IDLE: begin
        if (pop) begin
          coins_d = head.coins;
          tmr_d   = '0;
          if (head.prod)             state_d = S_MOTOR;
          else if (head.coins != '0) state_d = S_COIN;
        end
      end
      S_MOTOR: begin
        if (tmr_q == TMR_W'(PULSE_W - 1)) begin
          state_d = S_WAIT_DROP;
          tmr_d   = '0;
        end else begin
          tmr_d = tmr_q + 1'b1;
        end
      end
      S_WAIT_DROP: begin
        if (drop_sense) begin
          state_d = (coins_q != '0) ? S_COIN : S_IDLE;
          tmr_d   = '0;
        end else if (tmr_q == TMR_W'(TIMEOUT - 1)) begin
          state_d = S_FAULT;
        end else begin
          tmr_d = tmr_q + 1'b1;
        end
      end
      S_COIN: begin
        if (tmr_q == TMR_W'(PULSE_W - 1)) begin
          state_d = S_WAIT_COIN;
          tmr_d   = '0;
        end else begin
          tmr_d = tmr_q + 1'b1;
        end
      end
      S_WAIT_COIN: begin
        if (coin_sense) begin
          coins_d = coins_q - 1'b1;
          state_d = (coins_q != 2'd1) ? S_COIN : S_IDLE;
          tmr_d   = '0;
        end else if (tmr_q == TMR_W'(TIMEOUT - 1)) begin
          state_d = S_FAULT;
        end else begin
          tmr_d = tmr_q + 1'b1;
        end
      end
      S_FAULT: state_d = S_FAULT;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      tmr_q      <= '0;
      coins_q    <= '0;
      req_prev_q <= '0;
      mem_q      <= '{default: '0};
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      tmr_q      <= tmr_d;
      coins_q    <= coins_d;
      req_prev_q <= req_prev_d;
      mem_q      <= mem_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  assign motor    = (state_q == S_MOTOR);
  assign hopper   = (state_q == S_COIN);
  assign fault    = (state_q == S_FAULT);
  assign busy     = (state_q != S_IDLE) || (count_q != '0);
  assign overflow = overflow_q;

endmodule

// File: tb/tb_vend_dispense_ctrl.sv
// Bench for vend_dispense_ctrl: expected pulses queued at stimulus time, checked by an independent pulse monitor.
module tb_vend_dispense_ctrl;
  localparam int PW = 4;
  localparam int TO = 64;
  localparam int DP = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       out = 1'b0;
  logic [1:0] change = 2'd0;
  logic       drop_sense = 1'b0;
  logic       coin_sense = 1'b0;
  logic       motor, hopper, busy, full, overflow, fault;

  int total = 0;
  int bad   = 0;
  int exp_q[$];          // 0 = motor pulse, 1 = hopper pulse
  bit drop_auto = 1'b0;
  bit coin_auto = 1'b0;
  int drop_kick = 0;

  vend_dispense_ctrl #(.PULSE_W(PW), .TIMEOUT(TO), .DEPTH(DP)) dut (
    .clk(clk), .rst(rst), .out(out), .change(change),
    .drop_sense(drop_sense), .coin_sense(coin_sense),
    .motor(motor), .hopper(hopper), .busy(busy), .full(full),
    .overflow(overflow), .fault(fault)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int want);
    total++;
    if (act != want) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, want, $time);
    end
  endtask

  // Sensor model: answers 2 cycles after entry to a wait state, or once on demand.
  initial begin
    int drop_cd = 0;
    int coin_cd = 0;
    int kick_done = 0;
    bit m_prev = 1'b0;
    bit h_prev = 1'b0;
    forever begin
      @(posedge clk); #1;
      drop_sense = 1'b0;
      coin_sense = 1'b0;
      if (drop_cd > 0) begin drop_cd--; if (drop_cd == 0) drop_sense = 1'b1; end
      if (coin_cd > 0) begin coin_cd--; if (coin_cd == 0) coin_sense = 1'b1; end
      if (m_prev && !motor && drop_auto) drop_cd = 2;
      if (h_prev && !hopper && coin_auto) coin_cd = 2;
      if (kick_done != drop_kick) begin drop_sense = 1'b1; kick_done = drop_kick; end
      m_prev = motor;
      h_prev = hopper;
    end
  end

  // Monitor: every completed pulse is matched against the scoreboard queue.
  initial begin
    bit in_p = 1'b0;
    bit ab = 1'b0;
    int w = 0;
    int k = 0;
    int e;
    forever begin
      @(negedge clk);
      chk("exclusive_drive", int'(motor && hopper), 0);
      if (motor || hopper) begin
        if (!in_p) begin in_p = 1'b1; w = 0; k = int'(hopper); ab = 1'b0; end
        w++;
        if (!rst) ab = 1'b1;
      end else if (in_p) begin
        in_p = 1'b0;
        if (!ab) begin
          chk("pulse_expected", int'(exp_q.size() > 0), 1);
          if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("pulse_kind", k, e);
            chk("pulse_width", w, PW);
          end
        end
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic drive(input bit p, input logic [1:0] c);
    out = p;
    change = c;
  endtask

  task automatic expect_req(input bit p, input int c);
    if (p) exp_q.push_back(0);
    repeat (c) exp_q.push_back(1);
  endtask

  task automatic wait_level(input string nm, input int which, input bit lvl);
    bit found = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (((which != 0) ? hopper : motor) == lvl) begin found = 1'b1; break; end
    end
    chk(nm, int'(found), 1);
  endtask

  task automatic wait_idle(input string nm);
    bit found = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (!busy) begin found = 1'b1; break; end
    end
    chk(nm, int'(found), 1);
  endtask

  task automatic do_reset();
    tick(); rst = 1'b0;
    tick(); rst = 1'b1;
  endtask

  initial begin
    bit seen;
    // T1: reset held with out=1
    rst = 1'b0;
    drive(1'b1, 2'd0);
    repeat (3) tick();
    @(negedge clk);
    chk("t1_rst_motor", int'(motor), 0);
    chk("t1_rst_hopper", int'(hopper), 0);
    chk("t1_rst_busy", int'(busy), 0);
    chk("t1_rst_fault", int'(fault), 0);
    chk("t1_rst_full", int'(full), 0);
    chk("t1_rst_overflow", int'(overflow), 0);
    tick(); drive(1'b0, 2'd0);
    tick(); rst = 1'b1;
    drop_auto = 1'b1;
    tick(); drive(1'b1, 2'd0); expect_req(1'b1, 0);
    @(negedge clk); chk("t1_lat_cycN", int'(motor), 0);
    tick(); drive(1'b0, 2'd0);
    @(negedge clk); chk("t1_lat_cycN1", int'(motor), 0);
    @(negedge clk); chk("t1_lat_cycN2", int'(motor), 1);
    wait_idle("t1_idle");
    chk("t1_drained", exp_q.size(), 0);

    // T2: out=1, change=2 held 3 cycles
    coin_auto = 1'b1;
    tick(); drive(1'b1, 2'd2); expect_req(1'b1, 2);
    tick(); tick();
    tick(); drive(1'b0, 2'd0);
    wait_idle("t2_idle");
    chk("t2_drained", exp_q.size(), 0);
    chk("t2_fault", int'(fault), 0);

    // T3: coin sensor never answers
    coin_auto = 1'b0;
    tick(); drive(1'b0, 2'd1); expect_req(1'b0, 1);
    tick(); drive(1'b0, 2'd0);
    wait_level("t3_hopper_rise", 1, 1'b1);
    wait_level("t3_hopper_fall", 1, 1'b0);
    repeat (63) @(negedge clk);
    chk("t3_fault_before_timeout", int'(fault), 0);
    @(negedge clk);
    chk("t3_fault_at_timeout", int'(fault), 1);
    tick(); drive(1'b1, 2'd3);
    tick(); drive(1'b0, 2'd0);
    seen = 1'b0;
    repeat (20) begin @(negedge clk); if (motor || hopper) seen = 1'b1; end
    chk("t3_no_drive_in_fault", int'(seen), 0);
    chk("t3_queue_frozen", int'(full), 0);
    chk("t3_busy_in_fault", int'(busy), 1);
    do_reset();
    @(negedge clk); chk("t3_fault_cleared", int'(fault), 0);

    // T4: five requests while stalled in WAIT_DROP
    drop_auto = 1'b0;
    coin_auto = 1'b1;
    tick(); drive(1'b1, 2'd0); expect_req(1'b1, 0);
    tick(); drive(1'b0, 2'd0);
    wait_level("t4_motor_rise", 0, 1'b1);
    wait_level("t4_motor_fall", 0, 1'b0);
    tick(); drive(1'b1, 2'd1); expect_req(1'b1, 1);
    tick(); drive(1'b0, 2'd1); expect_req(1'b0, 1);
    tick(); drive(1'b1, 2'd2); expect_req(1'b1, 2);
    tick(); drive(1'b0, 2'd3); expect_req(1'b0, 3);
    @(negedge clk); chk("t4_full_after_3", int'(full), 0);
    tick(); drive(1'b1, 2'd3);
    @(negedge clk);
    chk("t4_full_after_4", int'(full), 1);
    chk("t4_no_overflow_yet", int'(overflow), 0);
    tick(); drive(1'b0, 2'd0);
    @(negedge clk); chk("t4_overflow_on_5th", int'(overflow), 1);
    drop_kick++;
    drop_auto = 1'b1;
    wait_idle("t4_idle");
    chk("t4_drained", exp_q.size(), 0);
    chk("t4_overflow_sticky", int'(overflow), 1);
    chk("t4_not_full", int'(full), 0);

    // T5: push in the same cycle IDLE pops a full queue
    do_reset();
    @(negedge clk); chk("t5_overflow_cleared", int'(overflow), 0);
    drop_auto = 1'b0;
    tick(); drive(1'b1, 2'd0); expect_req(1'b1, 0);
    tick(); drive(1'b0, 2'd0);
    wait_level("t5_motor_rise", 0, 1'b1);
    wait_level("t5_motor_fall", 0, 1'b0);
    tick(); drive(1'b0, 2'd1); expect_req(1'b0, 1);
    tick(); drive(1'b1, 2'd0); expect_req(1'b1, 0);
    tick(); drive(1'b0, 2'd1); expect_req(1'b0, 1);
    tick(); drive(1'b1, 2'd0); expect_req(1'b1, 0);
    tick(); drive(1'b0, 2'd0);
    @(negedge clk); chk("t5_full_before", int'(full), 1);
    drop_kick++;
    tick();
    tick(); drive(1'b1, 2'd1); expect_req(1'b1, 1);
    drop_auto = 1'b1;
    @(negedge clk); chk("t5_full_pop_cycle", int'(full), 1);
    tick(); drive(1'b0, 2'd0);
    @(negedge clk);
    chk("t5_full_after_push_pop", int'(full), 1);
    chk("t5_no_overflow", int'(overflow), 0);
    wait_idle("t5_idle");
    chk("t5_drained", exp_q.size(), 0);

    // T6: reset during a hopper pulse with more work queued
    tick(); drive(1'b0, 2'd2); expect_req(1'b0, 2);
    tick(); drive(1'b1, 2'd0); expect_req(1'b1, 0);
    tick(); drive(1'b0, 2'd0);
    wait_level("t6_hopper_rise", 1, 1'b1);
    tick(); rst = 1'b0;
    tick(); rst = 1'b1;
    @(negedge clk);
    chk("t6_hopper_dropped", int'(hopper), 0);
    chk("t6_busy_cleared", int'(busy), 0);
    chk("t6_full_cleared", int'(full), 0);
    exp_q.delete();
    seen = 1'b0;
    repeat (20) begin @(negedge clk); if (busy) seen = 1'b1; end
    chk("t6_queue_empty", int'(seen), 0);
    tick(); drive(1'b0, 2'd1); expect_req(1'b0, 1);
    tick(); drive(1'b0, 2'd0);
    wait_idle("t6_idle");
    chk("t6_drained", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
